iob_axi_ram_responder: RTL and testbench

// AXI4 responder (slave) backed by on-chip byte-enable RAM. Sits at the far end of the SoC external-memory
// AXI master port and stands in for DDR in simulation and DDR-less FPGA builds.

---
 rtl/iob_axi_ram_responder_pkg.sv | 29 ++
 rtl/iob_ram_sp_be.sv | 36 +++
 rtl/iob_axi_ram_responder.sv | 219 +++++++++++++++++++++
 tb/tb_iob_axi_ram_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_axi_ram_responder_pkg.sv
// Shared AXI encodings, FSM state type and arbitration pointer type for the RAM responder.
package iob_axi_ram_responder_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_DATA  = 3'd1,
      ST_WR_RESP  = 3'd2,
      ST_RD_FETCH = 3'd3,
      ST_RD_DATA  = 3'd4
   } state_t;

   typedef enum logic {
      RR_READ  = 1'b0,
      RR_WRITE = 1'b1
   } rr_t;

   // WRAP and the reserved encoding are served as error transactions.
   function automatic logic burst_is_err(input logic [1:0] burst);
      return !((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
   endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port byte-enable RAM with a one-cycle registered read; the read register holds when idle.
module iob_ram_sp_be #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
) (
   input  logic                clk_i,
   input  logic                en_i,
   input  logic [DATA_W/8-1:0] we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   d_i,
   output logic [DATA_W-1:0]   d_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] dout_q;

   // Byte-lane writes; a cycle with no strobes set is a read and refreshes the output register.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (we_i[b]) begin
               mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
            end
         end
         if (we_i == '0) begin
            dout_q <= mem[addr_i];
         end
      end
   end

   assign d_o = dout_q;

endmodule

// File: rtl/iob_axi_ram_responder.sv
// AXI4 responder backed by on-chip RAM: one transaction at a time, round-robin between read and write.
module iob_axi_ram_responder
   import iob_axi_ram_responder_pkg::*;
#(
   parameter int AXI_ID_W   = 4,
   parameter int AXI_LEN_W  = 8,
   parameter int AXI_ADDR_W = 24,
   parameter int AXI_DATA_W = 32,
   parameter int MEM_ADDR_W = 16
) (
   input  logic                    clk_i,
   input  logic                    arst_n_i,
   input  logic [AXI_ID_W-1:0]     axi_awid_i,
   input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
   input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
   input  logic [2:0]              axi_awsize_i,
   input  logic [1:0]              axi_awburst_i,
   input  logic [1:0]              axi_awlock_i,
   input  logic [3:0]              axi_awcache_i,
   input  logic [2:0]              axi_awprot_i,
   input  logic [3:0]              axi_awqos_i,
   input  logic                    axi_awvalid_i,
   output logic                    axi_awready_o,
   input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
   input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
   input  logic                    axi_wlast_i,
   input  logic                    axi_wvalid_i,
   output logic                    axi_wready_o,
   output logic [AXI_ID_W-1:0]     axi_bid_o,
   output logic [1:0]              axi_bresp_o,
   output logic                    axi_bvalid_o,
   input  logic                    axi_bready_i,
   input  logic [AXI_ID_W-1:0]     axi_arid_i,
   input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
   input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
   input  logic [2:0]              axi_arsize_i,
   input  logic [1:0]              axi_arburst_i,
   input  logic [1:0]              axi_arlock_i,
   input  logic [3:0]              axi_arcache_i,
   input  logic [2:0]              axi_arprot_i,
   input  logic [3:0]              axi_arqos_i,
   input  logic                    axi_arvalid_i,
   output logic                    axi_arready_o,
   output logic [AXI_ID_W-1:0]     axi_rid_o,
   output logic [AXI_DATA_W-1:0]   axi_rdata_o,
   output logic [1:0]              axi_rresp_o,
   output logic                    axi_rlast_o,
   output logic                    axi_rvalid_o,
   input  logic                    axi_rready_i
);

   localparam int STRB_W  = AXI_DATA_W / 8;
   localparam int ALIGN   = $clog2(STRB_W);
   localparam int WADDR_W = MEM_ADDR_W - ALIGN;
   localparam logic [MEM_ADDR_W-1:0] STEP     = MEM_ADDR_W'(STRB_W);
   localparam logic [AXI_LEN_W-1:0]  ONE_BEAT = AXI_LEN_W'(1);

   state_t                  state_q;
   rr_t                     rr_q;
   logic                    ready_en_q;
   logic [AXI_ID_W-1:0]     id_q;
   logic [MEM_ADDR_W-1:0]   addr_q;
   logic [MEM_ADDR_W-1:0]   addr_d;
   logic [AXI_LEN_W-1:0]    len_q;
   logic [AXI_LEN_W-1:0]    cnt_q;
   logic [AXI_LEN_W-1:0]    cnt_d;
   logic                    err_q;
   logic                    fixed_q;
   logic                    bvalid_q;
   logic [1:0]              bresp_q;
   logic                    rvalid_q;
   logic                    rlast_q;

   logic                    idle;
   logic                    ar_hs;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    last_beat;
   logic                    w_end;
   logic                    w_mism;
   logic                    r_adv;
   logic                    ram_wr;
   logic                    ram_en;
   logic [STRB_W-1:0]       ram_we;
   logic [AXI_DATA_W-1:0]   ram_dout;
   logic                    unused_in;

   // Arbitration: a lone request is always served, a contested cycle goes to the rr_q channel.
   assign idle          = (state_q == ST_IDLE);
   assign axi_arready_o = ready_en_q & idle & (~axi_awvalid_i | (rr_q == RR_READ));
   assign axi_awready_o = ready_en_q & idle & (~axi_arvalid_i | (rr_q == RR_WRITE));
   assign ar_hs         = axi_arvalid_i & axi_arready_o;
   assign aw_hs         = axi_awvalid_i & axi_awready_o;

   assign axi_wready_o  = (state_q == ST_WR_DATA);
   assign w_hs          = axi_wvalid_i & axi_wready_o;
   assign last_beat     = (cnt_q == len_q);
   assign w_end         = w_hs & (axi_wlast_i | last_beat);
   assign w_mism        = axi_wlast_i ^ last_beat;

   assign addr_d        = fixed_q ? addr_q : (addr_q + STEP);
   assign cnt_d         = cnt_q + ONE_BEAT;

   // RAM is read in RD_FETCH and on each accepted non-final beat, so it holds during R stalls.
   assign r_adv         = rvalid_q & axi_rready_i & ~rlast_q;
   assign ram_wr        = w_hs & ~err_q;
   assign ram_we        = ram_wr ? axi_wstrb_i : '0;
   assign ram_en        = (state_q == ST_RD_FETCH) | r_adv | ram_wr;

   iob_ram_sp_be #(
      .DATA_W (AXI_DATA_W),
      .ADDR_W (WADDR_W)
   ) u_ram (
      .clk_i  (clk_i),
      .en_i   (ram_en),
      .we_i   (ram_we),
      .addr_i (addr_q[MEM_ADDR_W-1:ALIGN]),
      .d_i    (axi_wdata_i),
      .d_o    (ram_dout)
   );

   assign axi_bvalid_o = bvalid_q;
   assign axi_bresp_o  = bresp_q;
   assign axi_bid_o    = id_q;
   assign axi_rvalid_o = rvalid_q;
   assign axi_rlast_o  = rlast_q;
   assign axi_rid_o    = id_q;
   assign axi_rresp_o  = (rvalid_q & err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign axi_rdata_o  = (rvalid_q & ~err_q) ? ram_dout : '0;

   // Transaction FSM with latched request fields, beat counter and registered B/R handshakes.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= ST_IDLE;
         rr_q       <= RR_READ;
         ready_en_q <= 1'b0;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         fixed_q    <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= AXI_RESP_OKAY;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (ar_hs) begin
                  id_q    <= axi_arid_i;
                  addr_q  <= axi_araddr_i[MEM_ADDR_W-1:0];
                  len_q   <= axi_arlen_i;
                  cnt_q   <= '0;
                  err_q   <= burst_is_err(axi_arburst_i);
                  fixed_q <= (axi_arburst_i == AXI_BURST_FIXED);
                  rr_q    <= RR_WRITE;
                  state_q <= ST_RD_FETCH;
               end else if (aw_hs) begin
                  id_q    <= axi_awid_i;
                  addr_q  <= axi_awaddr_i[MEM_ADDR_W-1:0];
                  len_q   <= axi_awlen_i;
                  cnt_q   <= '0;
                  err_q   <= burst_is_err(axi_awburst_i);
                  fixed_q <= (axi_awburst_i == AXI_BURST_FIXED);
                  rr_q    <= RR_READ;
                  state_q <= ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (w_hs) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_d;
                  if (w_end) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= (err_q | w_mism) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                     state_q  <= ST_WR_RESP;
                  end
               end
            end
            ST_WR_RESP: begin
               if (axi_bready_i) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= AXI_RESP_OKAY;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RD_FETCH: begin
               rvalid_q <= 1'b1;
               rlast_q  <= last_beat;
               addr_q   <= addr_d;
               state_q  <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (rvalid_q & axi_rready_i) begin
                  if (rlast_q) begin
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     state_q  <= ST_IDLE;
                  end else begin
                     cnt_q   <= cnt_d;
                     rlast_q <= (cnt_d == len_q);
                     addr_q  <= addr_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sideband fields the responder deliberately does not interpret.
   assign unused_in = ^{axi_awsize_i, axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i,
                        axi_arsize_i, axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i,
                        axi_awaddr_i[AXI_ADDR_W-1:MEM_ADDR_W], axi_araddr_i[AXI_ADDR_W-1:MEM_ADDR_W],
                        addr_q[ALIGN-1:0]};

endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Directed bench for the AXI RAM responder: bursts, strobes, arbitration, stalls, errors, wrap, reset.
module tb_iob_axi_ram_responder;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic [3:0]  awid = '0, arid = '0;
   logic [23:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [1:0]  awburst = '0, arburst = '0;
   logic        awvalid = 1'b0, arvalid = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [3:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int checks = 0;
   int failures = 0;

   logic [31:0] wd [8];
   logic [3:0]  ws [8];
   logic [31:0] rd [16];
   int          nb, last_at, first_v, stall_err;
   logic        extra_v;
   logic [3:0]  bid_cap, rid_cap;
   logic [1:0]  bresp_cap, rresp_cap;

   always #5 clk = ~clk;

   iob_axi_ram_responder dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(3'd2),
      .axi_awburst_i(awburst), .axi_awlock_i(2'd0), .axi_awcache_i(4'd0), .axi_awprot_i(3'd0),
      .axi_awqos_i(4'd0), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
      .axi_wready_o(wready), .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
      .axi_bready_i(bready),
      .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(3'd2),
      .axi_arburst_i(arburst), .axi_arlock_i(2'd0), .axi_arcache_i(4'd0), .axi_arprot_i(3'd0),
      .axi_arqos_i(4'd0), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
      .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
      .axi_rvalid_o(rvalid), .axi_rready_i(rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [23:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
      bit hs = 0;
      arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #3 hs = arready;
         @(negedge clk);
         if (hs) break;
      end
      arvalid = 1'b0;
      chk("ar_handshake", hs, 1);
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [23:0] a, input logic [7:0] len,
                          input logic [1:0] burst);
      bit hs = 0;
      awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #3 hs = awready;
         @(negedge clk);
         if (hs) break;
      end
      awvalid = 1'b0;
      chk("aw_handshake", hs, 1);
   endtask

   task automatic w_send(input int nbeats, input int wlast_at);
      bit hs;
      for (int b = 0; b < nbeats; b++) begin
         hs = 0;
         wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_at); wvalid = 1'b1;
         for (int n = 0; n < 50; n++) begin
            #3 hs = wready;
            @(negedge clk);
            if (hs) break;
         end
         chk("w_handshake", hs, 1);
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic b_collect();
      bit got = 0;
      bready = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #3 if (bvalid) begin got = 1; bid_cap = bid; bresp_cap = bresp; end
         @(negedge clk);
         if (got) break;
      end
      bready = 1'b0;
      chk("b_handshake", got, 1);
   endtask

   task automatic r_collect(input logic [15:0] pat);
      bit done = 0, prev_stall = 0, v, l, pl = 0;
      logic [31:0] d, pd = '0;
      nb = 0; last_at = -1; first_v = -1; stall_err = 0;
      for (int c = 0; c < 300 && !done; c++) begin
         rready = pat[c % 16];
         #3 v = rvalid; d = rdata; l = rlast;
         if (prev_stall && !(v && d === pd && l === pl)) stall_err++;
         if (v && first_v < 0) first_v = c;
         if (v && rready) begin
            if (nb < 16) rd[nb] = d;
            if (l) begin last_at = nb; done = 1; rresp_cap = rresp; rid_cap = rid; end
            nb++;
         end
         prev_stall = v && !rready;
         pd = d; pl = l;
         @(negedge clk);
      end
      rready = 1'b0;
      extra_v = rvalid;
   endtask

   initial begin
      // reset state
      #12;
      chk("reset_outputs", {awready, arready, wready, bvalid, rvalid, rlast, bid, rid, bresp, rresp, rdata},
          64'd0);
      @(negedge clk) arst_n = 1'b1;
      #3 chk("ready_en_first_cycle", arready, 0);
      @(negedge clk);
      chk("ready_en_after_clk", {arready, awready}, 2'b11);
      @(negedge clk);

      // 1: INCR len=3 write then read back
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      for (int i = 0; i < 8; i++) ws[i] = 4'hF;
      aw_send(4'd5, 24'h000100, 8'd3, INCR); w_send(4, 3); b_collect();
      chk("t1_bresp", bresp_cap, 2'b00);
      chk("t1_bid", bid_cap, 4'd5);
      ar_send(4'd9, 24'h000100, 8'd3, INCR); r_collect(16'hFFFF);
      chk("t1_latency", first_v, 1);
      chk("t1_beats", nb, 4);
      chk("t1_data", {rd[0], rd[1]}, {32'h11, 32'h22});
      chk("t1_data_hi", {rd[2], rd[3]}, {32'h33, 32'h44});
      chk("t1_rlast_pos", last_at, 3);
      chk("t1_rresp_rid", {rresp_cap, rid_cap}, {2'b00, 4'd9});
      chk("t1_no_extra", extra_v, 0);

      // 2: byte strobe merge
      wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
      aw_send(4'd1, 24'h000020, 8'd0, INCR); w_send(1, 0); b_collect();
      wd[0] = 32'h0; ws[0] = 4'h2;
      aw_send(4'd1, 24'h000020, 8'd0, INCR); w_send(1, 0); b_collect();
      ar_send(4'd2, 24'h000020, 8'd0, INCR); r_collect(16'hFFFF);
      chk("t2_strobe_merge", rd[0], 32'hAABB00DD);
      chk("t2_single_rlast", {nb, last_at}, {32'd1, 32'd0});

      // 4: len=7 read with rready 1,0,0,1,... stalls
      for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0000000 + i; ws[i] = 4'hF; end
      aw_send(4'd3, 24'h000200, 8'd7, INCR); w_send(8, 7); b_collect();
      chk("t4_bresp", bresp_cap, 2'b00);
      ar_send(4'd7, 24'h000200, 8'd7, INCR); r_collect(16'b1001_1001_1001_1001);
      chk("t4_beats", nb, 8);
      chk("t4_stall_stable", stall_err, 0);
      chk("t4_rlast_pos", last_at, 7);
      chk("t4_d0_d1", {rd[0], rd[1]}, {32'hA0000000, 32'hA0000001});
      chk("t4_d2_d3", {rd[2], rd[3]}, {32'hA0000002, 32'hA0000003});
      chk("t4_d4_d5", {rd[4], rd[5]}, {32'hA0000004, 32'hA0000005});
      chk("t4_d6_d7", {rd[6], rd[7]}, {32'hA0000006, 32'hA0000007});

      // 5: WRAP is an error transaction; early wlast is SLVERR but data stays
      wd[0] = 32'hDEADBEEF; wd[1] = 32'hDEADBEEF; ws[0] = 4'hF; ws[1] = 4'hF;
      aw_send(4'd4, 24'h000100, 8'd1, WRAP); w_send(2, 1); b_collect();
      chk("t5_wrap_bresp", bresp_cap, 2'b10);
      ar_send(4'd4, 24'h000100, 8'd1, INCR); r_collect(16'hFFFF);
      chk("t5_ram_unchanged", {rd[0], rd[1]}, {32'h11, 32'h22});
      ar_send(4'd6, 24'h000100, 8'd1, WRAP); r_collect(16'hFFFF);
      chk("t5_wrap_rdata", {rd[0], rd[1]}, 64'd0);
      chk("t5_wrap_rresp", {rresp_cap, rid_cap}, {2'b10, 4'd6});
      chk("t5_wrap_beats", nb, 2);
      wd[0] = 32'h55; wd[1] = 32'h66;
      aw_send(4'd8, 24'h000300, 8'd3, INCR); w_send(2, 1); b_collect();
      chk("t5_early_wlast_bresp", {bresp_cap, bid_cap}, {2'b10, 4'd8});
      ar_send(4'd8, 24'h000300, 8'd1, INCR); r_collect(16'hFFFF);
      chk("t5_early_beats_kept", {rd[0], rd[1]}, {32'h55, 32'h66});

      // 6: address wrap at 2^16
      wd[0] = 32'h77; wd[1] = 32'h88;
      aw_send(4'd2, 24'h00FFFC, 8'd1, INCR); w_send(2, 1); b_collect();
      chk("t6_wrap_bresp", bresp_cap, 2'b00);
      ar_send(4'd2, 24'h000000, 8'd0, INCR); r_collect(16'hFFFF);
      chk("t6_second_beat_at_0", rd[0], 32'h88);
      ar_send(4'd2, 24'h00FFFC, 8'd0, INCR); r_collect(16'hFFFF);
      chk("t6_first_beat_top", rd[0], 32'h77);
      ar_send(4'd2, 24'h010000, 8'd0, INCR); r_collect(16'hFFFF);
      chk("t6_upper_bits_ignored", rd[0], 32'h88);

      // 6: reset mid-read
      ar_send(4'd3, 24'h000200, 8'd7, INCR);
      rready = 1'b0;
      @(negedge clk);
      chk("rst_rvalid_before", rvalid, 1);
      #2 arst_n = 1'b0;
      #1 chk("rst_async_drop", {awready, arready, wready, bvalid, rvalid, rlast, rdata}, 64'd0);
      arid = 4'd1; araddr = 24'h000100; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
      awid = 4'd2; awaddr = 24'h000040; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
      @(negedge clk) arst_n = 1'b1;
      #3 chk("rst_readies_low_after_release", {arready, awready}, 2'b00);

      // 3: contested AR/AW after reset -> read first, then write, and no write starvation
      @(negedge clk);
      chk("t3_read_wins", {arready, awready}, 2'b10);
      @(negedge clk);
      arvalid = 1'b0;
      #1 chk("t3_aw_blocked_during_read", awready, 0);
      r_collect(16'hFFFF);
      chk("t3_read_data", {rd[0], 28'd0, rid_cap}, {32'h11, 28'd0, 4'd1});
      #1 chk("t3_write_next", awready, 1);
      wd[0] = 32'h12345678; ws[0] = 4'hF;
      aw_send(4'd2, 24'h000040, 8'd0, INCR); w_send(1, 0); b_collect();
      chk("t3_write_b", {bresp_cap, bid_cap}, {2'b00, 4'd2});
      arid = 4'd4; araddr = 24'h000040; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
      awid = 4'd6; awaddr = 24'h000044; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
      #1 chk("t3_second_read_wins", {arready, awready}, 2'b10);
      @(negedge clk);
      r_collect(16'hFFFF);
      chk("t3_second_read_data", rd[0], 32'h12345678);
      #1 chk("t3_write_not_starved", {arready, awready}, 2'b01);
      wd[0] = 32'hCAFEF00D;
      aw_send(4'd6, 24'h000044, 8'd0, INCR); w_send(1, 0); b_collect();
      chk("t3_starve_b", {bresp_cap, bid_cap}, {2'b00, 4'd6});
      ar_send(4'd4, 24'h000044, 8'd0, INCR); r_collect(16'hFFFF);
      chk("t3_final_read", rd[0], 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
